// File: rtl/serial_compare.sv
// Bit-serial WIDTH-bit magnitude comparator producing registered equal/greater/less flags.
// Define SERIAL_CMP_LSB_FIRST_EN for LSB-first operand streams (default is MSB-first).
module serial_compare #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic esit,
    output logic buyuk,
    output logic kucuk
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           decided_q, decided_d;
    logic           gt_q, gt_d;
    logic           esit_q, esit_d;
    logic           buyuk_q, buyuk_d;
    logic           kucuk_q, kucuk_d;
    logic           diff;

    assign diff = a_bit ^ b_bit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        esit_d    = esit_q;
        buyuk_d   = buyuk_q;
        kucuk_d   = kucuk_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end
            end
            RUN: begin
                // start has priority over a bit pair presented in the same cycle
                if (start) begin
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end else if (bit_valid) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_CMP_LSB_FIRST_EN
                    if (diff) begin
`else
                    if (diff && !decided_q) begin
`endif
                        decided_d = 1'b1;
                        gt_d      = a_bit;
                    end
                    // Flags are registered on the way into DONE so they are visible with done
                    if (cnt_q == LAST_IDX) begin
                        state_d = DONE;
                        esit_d  = ~decided_d;
                        buyuk_d = decided_d & gt_d;
                        kucuk_d = decided_d & ~gt_d;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            esit_q    <= 1'b0;
            buyuk_q   <= 1'b0;
            kucuk_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            esit_q    <= esit_d;
            buyuk_q   <= buyuk_d;
            kucuk_q   <= kucuk_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign esit  = esit_q;
    assign buyuk = buyuk_q;
    assign kucuk = kucuk_q;

endmodule
